// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding,
// default memory map, and requester port identifiers.
package dmem_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DMEM_BASE_ADDR = 32'h1001_0000;
  localparam int                DMEM_DEPTH     = 1024;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: request/accept
// handshake plus the completion response. The requester drives the
// master modport; the arbiter sits on the slave modport.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker. When both requesters are active the
// one that did not win last time is chosen; the remembered winner only
// moves when the caller strobes accept.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last_q;

  // Winner selection: a lone requester always wins, contention alternates.
  always_comb begin
    grant_id = PORT_CPU;
    grant    = 2'b00;
    case (req)
      2'b01:   grant_id = PORT_CPU;
      2'b10:   grant_id = PORT_DBG;
      2'b11:   grant_id = ~last_q;
      default: grant_id = PORT_CPU;
    endcase
    if (req != 2'b00) begin
      grant = (grant_id == PORT_DBG) ? 2'b10 : 2'b01;
    end
  end

  // Remember the last accepted port; starting at DBG lets the CPU win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_DBG;
    end else if (accept) begin
      last_q <= grant_id;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory.
// Port 0 (p0) is the CPU data port, port 1 (p1) the debug/DMA loader.
// Each transaction runs IDLE -> ACCESS -> RESP; only one is in flight.
// Optional build macro DMEM_ARB_PERF_EN adds saturating grant and
// contention counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DMEM_BASE_ADDR,
  parameter int                DEPTH     = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic              mem_ena,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       p0_grant_cnt,
  output logic [31:0]       p1_grant_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  // Offset is taken modulo 2^32; the lower-bound compare rejects addresses
  // below the base that would otherwise wrap into a small offset.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        req_vec;
  logic [1:0]        grant;
  logic              grant_id;
  logic              accept;

  logic              we_q;
  logic              port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              in_rng;
  logic              resp;

  assign req_vec = {p1.req, p0.req};
  assign accept  = (state_q == ST_IDLE) && (req_vec != 2'b00);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_vec),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in IDLE, one access cycle, one response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Accept pulse goes straight back to the winner in the IDLE cycle.
  assign p0.ready = accept && grant[0];
  assign p1.ready = accept && grant[1];

  // Capture the winning request so requesters may drop it after ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      port_q  <= PORT_CPU;
    end else if (accept) begin
      addr_q  <= (grant_id == PORT_DBG) ? p1.addr  : p0.addr;
      wdata_q <= (grant_id == PORT_DBG) ? p1.wdata : p0.wdata;
      we_q    <= (grant_id == PORT_DBG) ? p1.we    : p0.we;
      port_q  <= grant_id;
    end
  end

  // ---- access stage: memory is driven only here, and only when in range
  assign in_rng    = addr_in_range(addr_q);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ena   = (state_q == ST_ACCESS) && in_rng;
  assign mem_wena  = mem_ena && we_q;

  // Latch the access result; writes and rejected accesses return zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == ST_ACCESS) begin
      rdata_q <= (in_rng && !we_q) ? mem_rdata : '0;
      err_q   <= !in_rng;
    end
  end

  // ---- response stage: one-cycle pulse to the owner, the other port stays quiet
  assign resp      = (state_q == ST_RESP);
  assign p0.rvalid = resp && (port_q == PORT_CPU);
  assign p1.rvalid = resp && (port_q == PORT_DBG);
  assign p0.rdata  = p0.rvalid ? rdata_q : '0;
  assign p1.rdata  = p1.rvalid ? rdata_q : '0;
  assign p0.err    = p0.rvalid && err_q;
  assign p1.err    = p1.rvalid && err_q;

`ifdef DMEM_ARB_PERF_EN
  // Saturating grant and contention statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_grant_cnt <= '0;
      p1_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (p0.ready) p0_grant_cnt <= sat_inc(p0_grant_cnt);
      if (p1.ready) p1_grant_cnt <= sat_inc(p1_grant_cnt);
      if ((state_q == ST_IDLE) && (req_vec == 2'b11)) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, reset corner cases,
// then randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ena, mem_wena;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] p0_grant_cnt, p1_grant_cnt, conflict_cnt;
  int          m_grant0, m_grant1, m_conf;
`endif

  logic [1:0]  req_v, we_v;
  logic [31:0] addr_v [2];
  logic [31:0] wdata_v [2];

  dmem_arbiter_if p0_if ();
  dmem_arbiter_if p1_if ();

  assign p0_if.req   = req_v[0];
  assign p0_if.we    = we_v[0];
  assign p0_if.addr  = addr_v[0];
  assign p0_if.wdata = wdata_v[0];
  assign p1_if.req   = req_v[1];
  assign p1_if.we    = we_v[1];
  assign p1_if.addr  = addr_v[1];
  assign p1_if.wdata = wdata_v[1];

  logic [1:0]  rdy_o, rvalid_o, err_o;
  logic [31:0] rdata_o [2];
  assign rdy_o      = {p1_if.ready, p0_if.ready};
  assign rvalid_o   = {p1_if.rvalid, p0_if.rvalid};
  assign err_o      = {p1_if.err, p0_if.err};
  assign rdata_o[0] = p0_if.rdata;
  assign rdata_o[1] = p1_if.rdata;

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0        (p0_if),
    .p1        (p1_if),
    .mem_ena   (mem_ena),
    .mem_wena  (mem_wena),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .p0_grant_cnt (p0_grant_cnt),
    .p1_grant_cnt (p1_grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory: unwritten words read as 0xA5000000 | offset.
  logic [31:0] mem [DEPTH];
  bit          written [DEPTH];
  logic [31:0] moff;
  assign moff      = mem_addr - BASE;
  assign mem_rdata = written[moff[9:0]] ? mem[moff[9:0]] : (32'hA500_0000 | {22'd0, moff[9:0]});
  always @(posedge clk) begin
    if (mem_ena && mem_wena) begin
      mem[moff[9:0]]     <= mem_wdata;
      written[moff[9:0]] <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          ref_last;
  int          checks = 0;
  int          errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + longint'(DEPTH));
  endfunction

  task automatic set_port(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_v[p]   = 1'b1;
    we_v[p]    = w;
    addr_v[p]  = a;
    wdata_v[p] = d;
  endtask

  task automatic model_reset();
`ifdef DMEM_ARB_PERF_EN
    m_grant0 = 0;
    m_grant1 = 0;
    m_conf   = 0;
`endif
    ref_last = 1;
  endtask

  // Entered at posedge+1 with DUT idle and requests set up; runs one full
  // transaction (3 cycles) and returns at posedge+1.
  task automatic step_txn(input string tag, input int ep, input logic eerr, input logic [31:0] erd);
    int          op;
    logic        inr;
    logic [31:0] a;
    op  = 1 - ep;
    a   = addr_v[ep];
    inr = model_in_range(a);
    @(negedge clk);
    chk1({tag, "_ready_win"}, rdy_o[ep], 1'b1);
    chk1({tag, "_ready_lose"}, rdy_o[op], 1'b0);
`ifdef DMEM_ARB_PERF_EN
    if (req_v == 2'b11) m_conf++;
    if (ep == 0) m_grant0++; else m_grant1++;
`endif
    @(posedge clk);
    #1 req_v[ep] = 1'b0;
    @(negedge clk);
    chk1({tag, "_mem_ena"}, mem_ena, !eerr);
    chk1({tag, "_mem_wena"}, mem_wena, !eerr && we_v[ep]);
    chk32({tag, "_mem_addr"}, mem_addr, a);
    chk32({tag, "_mem_wdata"}, mem_wdata, wdata_v[ep]);
    chk32({tag, "_busy_ready"}, {30'd0, rdy_o}, 32'd0);
    chk32({tag, "_early_rvalid"}, {30'd0, rvalid_o}, 32'd0);
    @(posedge clk);
    if (inr && we_v[ep]) ref_mem[a - BASE] = wdata_v[ep];
    @(negedge clk);
    chk1({tag, "_rvalid"}, rvalid_o[ep], 1'b1);
    chk1({tag, "_err"}, err_o[ep], eerr);
    chk32({tag, "_rdata"}, rdata_o[ep], erd);
    chk1({tag, "_other_rvalid"}, rvalid_o[op], 1'b0);
    chk1({tag, "_other_err"}, err_o[op], 1'b0);
    chk32({tag, "_other_rdata"}, rdata_o[op], 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + DEPTH - 1;
      1:       return BASE + DEPTH + $urandom_range(0, 15);
      2:       return BASE - 1 - $urandom_range(0, 15);
      3:       return $urandom();
      default: return BASE + $urandom_range(0, DEPTH - 1);
    endcase
  endfunction

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0, d0, a1, d1;
    int          port;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [12];

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pend [2];
    int          w;
    logic        inr;
    logic [31:0] erd;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hA500_0000 | i;
    tbl[0]  = '{2'b11, 2'b00, 32'h1001_0004, 32'h0, 32'h1001_0008, 32'h0, 0, 1'b0, 32'hA500_0004};
    tbl[1]  = '{2'b10, 2'b00, 32'h0,         32'h0, 32'h1001_0008, 32'h0, 1, 1'b0, 32'hA500_0008};
    tbl[2]  = '{2'b11, 2'b00, 32'h1001_0000, 32'h0, 32'h1001_03FF, 32'h0, 0, 1'b0, 32'hA500_0000};
    tbl[3]  = '{2'b11, 2'b00, 32'h1001_0004, 32'h0, 32'h1001_03FF, 32'h0, 1, 1'b0, 32'hA500_03FF};
    tbl[4]  = '{2'b11, 2'b01, 32'h1001_0004, 32'hDEADBEEF, 32'h1001_0400, 32'h0, 0, 1'b0, 32'h0};
    tbl[5]  = '{2'b11, 2'b00, 32'h1001_0004, 32'h0, 32'h1001_0400, 32'h0, 1, 1'b1, 32'h0};
    tbl[6]  = '{2'b01, 2'b00, 32'h1001_0004, 32'h0, 32'h0, 32'h0, 0, 1'b0, 32'hDEADBEEF};
    tbl[7]  = '{2'b01, 2'b01, 32'h1000_FFFF, 32'h1111_1111, 32'h0, 32'h0, 0, 1'b1, 32'h0};
    tbl[8]  = '{2'b01, 2'b00, 32'h1001_0000, 32'h0, 32'h0, 32'h0, 0, 1'b0, 32'hA500_0000};
    tbl[9]  = '{2'b10, 2'b10, 32'h0, 32'h0, 32'h1001_0000, 32'hCAFE_F00D, 1, 1'b0, 32'h0};
    tbl[10] = '{2'b10, 2'b00, 32'h0, 32'h0, 32'h1001_0000, 32'h0, 1, 1'b0, 32'hCAFE_F00D};
    tbl[11] = '{2'b01, 2'b00, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0};

    req_v = 2'b00; we_v = 2'b00;
    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
    rst_n = 1'b0;
    model_reset();
    #3;
    chk32("rst_ready", {30'd0, rdy_o}, 32'd0);
    chk32("rst_rvalid", {30'd0, rvalid_o}, 32'd0);
    chk32("rst_err", {30'd0, err_o}, 32'd0);
    chk1("rst_mem_ena", mem_ena, 1'b0);
    chk1("rst_mem_wena", mem_wena, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk32("rst_mem_wdata", mem_wdata, 32'd0);
    chk32("rst_rdata0", rdata_o[0], 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;

    // No request: arbiter stays idle
    repeat (2) begin
      @(negedge clk);
      chk32("idle_ready", {30'd0, rdy_o}, 32'd0);
      chk1("idle_mem_ena", mem_ena, 1'b0);
      chk32("idle_rvalid", {30'd0, rvalid_o}, 32'd0);
    end
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].req[0]) set_port(0, tbl[i].we[0], tbl[i].a0, tbl[i].d0); else req_v[0] = 1'b0;
      if (tbl[i].req[1]) set_port(1, tbl[i].we[1], tbl[i].a1, tbl[i].d1); else req_v[1] = 1'b0;
      step_txn($sformatf("vec%0d", i), tbl[i].port, tbl[i].err, tbl[i].rdata);
    end
`ifdef DMEM_ARB_PERF_EN
    chk32("perf_tbl_p0", p0_grant_cnt, m_grant0);
    chk32("perf_tbl_p1", p1_grant_cnt, m_grant1);
    chk32("perf_tbl_conf", conflict_cnt, m_conf);
`endif

    // Reset during the access cycle of a write: nothing may commit
    set_port(0, 1'b1, 32'h1001_0008, 32'h1234_5678);
    @(negedge clk);
    chk1("mw_ready", rdy_o[0], 1'b1);
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    @(negedge clk);
    chk1("mw_wena_pre", mem_wena, 1'b1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk1("mw_wena_rst", mem_wena, 1'b0);
    chk1("mw_ena_rst", mem_ena, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk32("mw_no_rvalid", {30'd0, rvalid_o}, 32'd0);
    end
    @(posedge clk); #1;
    set_port(0, 1'b0, 32'h1001_0008, 32'h0);
    step_txn("mw_readback", 0, 1'b0, 32'hA500_0008);

    // Reset while in the response cycle: the pulse must not appear
    set_port(1, 1'b0, 32'h1001_0010, 32'h0);
    @(negedge clk);
    chk1("rr_ready", rdy_o[1], 1'b1);
    @(posedge clk);
    #1 req_v[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk32("rr_no_rvalid", {30'd0, rvalid_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int t = 0; t < 300; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
          pend[p] = 1'b1;
          set_port(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1;
        set_port(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      end
      if (pend[0] && pend[1]) w = (ref_last == 0) ? 1 : 0;
      else                    w = pend[1] ? 1 : 0;
      inr = model_in_range(addr_v[w]);
      erd = (inr && !we_v[w]) ? ref_mem[addr_v[w] - BASE] : 32'd0;
      step_txn($sformatf("rnd%0d", t), w, !inr, erd);
      pend[w]  = 1'b0;
      ref_last = w;
    end
    // Drain a request still waiting
    for (int p = 0; p < 2; p++) begin
      if (pend[p]) begin
        inr = model_in_range(addr_v[p]);
        erd = (inr && !we_v[p]) ? ref_mem[addr_v[p] - BASE] : 32'd0;
        step_txn("rnd_drain", p, !inr, erd);
      end
    end
`ifdef DMEM_ARB_PERF_EN
    chk32("perf_rnd_p0", p0_grant_cnt, m_grant0);
    chk32("perf_rnd_p1", p1_grant_cnt, m_grant1);
    chk32("perf_rnd_conf", conflict_cnt, m_conf);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port data memory (1024 x 32-bit, base 32'h10010000, combinational read, write on posedge clk).
- Port 0 is the CPU data port; port 1 is the debug/DMA loader port.
- Grants one transaction at a time, round-robin, and range-checks the address.
- Drives the memory enables, latches read data, and returns a registered response pulse to the granted requester.

Parameters:
- BASE_ADDR, 32'h10010000, first valid address; mapped to memory word 0.
- DEPTH, 1024, number of memory words; valid offsets are 0..DEPTH-1.

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- p0_req / p1_req  in  1  transaction request; hold until ready
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  32  unit-step word address (offset = addr - BASE_ADDR)
- p0_wdata / p1_wdata  in  32  write data
- p0_ready / p1_ready  out  1  one-cycle accept pulse
- p0_rvalid / p1_rvalid  out  1  one-cycle completion pulse (reads and writes)
- p0_rdata / p1_rdata  out  32  read data, valid with rvalid
- p0_err / p1_err  out  1  out-of-range flag, valid with rvalid
- mem_ena  out  1  memory enable
- mem_wena  out  1  memory write enable
- mem_addr  out  32  address to memory (full address, not offset)
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  memory read data (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 (port 0 wins first).
  - All ready/rvalid/err/mem_ena/mem_wena = 0.
  - rdata, mem_addr and mem_wdata regs = 0.
- FSM IDLE -> ACCESS -> RESP -> IDLE. Three cycles per transaction; at most one transaction in flight.
- IDLE:
  - If any req is high, pick a winner; readyN=1 combinationally this cycle.
  - Latch addr, we, wdata and port id; go ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one request high: that port wins.
  - Both high: the port != last_grant wins.
  - last_grant updates on accept.
- ACCESS:
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - In range (addr >= BASE_ADDR and addr - BASE_ADDR < DEPTH): mem_ena=1, mem_wena = latched we. The write commits at this edge; for a read, mem_rdata is captured into rdata_q at this edge.
  - Out of range: mem_ena=0, mem_wena=0, err_q=1, rdata_q=0.
  - Go RESP.
- RESP:
  - rvalid of the latched port = 1 for exactly one cycle.
  - rdata = rdata_q (0 for writes), err = err_q.
  - The other port's rvalid, rdata and err stay 0.
  - Go IDLE.
- Latency: req seen in IDLE -> ready in the same cycle -> rvalid 2 cycles later.
- Requester rules:
  - Hold req/we/addr/wdata stable until ready.
  - Do not re-request before the own rvalid; a req seen in ACCESS or RESP waits.
- Boundaries:
  - addr = BASE_ADDR + DEPTH - 1 is valid.
  - BASE_ADDR + DEPTH and BASE_ADDR - 1 give err.
  - The offset subtraction is 32-bit unsigned; the comparison against BASE_ADDR prevents wrap-around aliasing.
- Reset mid-operation:
  - Asserted in ACCESS before the edge: no write commits.
  - Asserted in RESP: no rvalid is produced.
  - The FSM restarts in IDLE.
- mem_ena and mem_wena are never high outside ACCESS.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs p0_grant_cnt and p1_grant_cnt (32 bits each, reset 0).
  - Each counter increments on its port's ready pulse and saturates at 32'hFFFFFFFF.
  - Adds output conflict_cnt (32 bits, reset 0), which increments in every IDLE cycle where both reqs are high. It also saturates.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - Default BASE_ADDR and DEPTH constants.
  - Port-id constants PORT_CPU=0, PORT_DBG=1.
- One sub-module, rr_arb2: two-requester round-robin picker with last_grant register and accept strobe.
- The FSM, latches and range check stay in dmem_arbiter.

Test Plan:
- Basic write/read:
  - p0 write addr 32'h10010004, data 32'hDEADBEEF: p0_ready in cycle 0; mem_ena=1, mem_wena=1 in cycle 1; p0_rvalid=1, err=0 in cycle 2.
  - Then p0 read of the same address: p0_rdata=32'hDEADBEEF, err=0.
- Simultaneous requests after reset:
  - p0 and p1 both read: p0 is granted first, p1_ready 3 cycles later.
  - Repeat with both held: grants alternate p0, p1, p0, p1.
- Upper boundary:
  - Read 32'h100103FF: mem_ena=1, err=0.
  - Read 32'h10010400: mem_ena stays 0, p1_rvalid with err=1, rdata=0.
- Lower boundary and no write on error:
  - Write to 32'h1000FFFF: err=1.
  - A following read of 32'h10010000 returns its prior value (memory untouched).
- Reset mid-write:
  - Drop rst_n during ACCESS of a write of 32'h12345678 to 32'h10010008.
  - After release: no rvalid, FSM in IDLE, a read of 32'h10010008 returns the old value.
- With DMEM_ARB_PERF_EN defined:
  - 5 p0 grants and 3 p1 grants with 2 contended IDLE cycles: p0_grant_cnt=5, p1_grant_cnt=3, conflict_cnt=2.
